// File: rtl/spi_master_arbiter.sv
// spi_master_arbiter: shares one SPI Master among NUM_REQ requesters.
// Round-robin arbitration by default; define SPI_ARB_FIXED_PRI_EN for fixed
// priority (lowest index wins, pointer held at 0).
// Completion is tracked from the Master's chip selects, with a per-state
// timeout that aborts the transfer and reports err with the ack.
module spi_master_arbiter #(
   parameter int NUM_REQ        = 3,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [NUM_REQ-1:0]     req,
   input  logic [2*NUM_REQ-1:0]   req_sel,
   input  logic [8*NUM_REQ-1:0]   req_data,
   output logic [NUM_REQ-1:0]     ack,
   output logic [7:0]             rx_data,
   output logic                   err,
   output logic                   busy,
   output logic [2:0]             grant_id,
   output logic                   mst_start,
   output logic [1:0]             mst_slave_select,
   output logic [7:0]             mst_data_to_send,
   input  logic [7:0]             mst_data_received,
   input  logic [2:0]             mst_cs
);

   localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [2:0] CS_IDLE = 3'b111;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      LAUNCH    = 3'd1,
      WAIT_ACT  = 3'd2,
      WAIT_DONE = 3'd3,
      COMPLETE  = 3'd4
   } state_t;

   state_t              state_q, state_d;
   logic [2:0]          ptr_q, ptr_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [2:0]          grant_id_q, grant_id_d;
   logic [1:0]          sel_q, sel_d;
   logic [7:0]          data_q, data_d;
   logic [7:0]          rx_data_q, rx_data_d;
   logic [NUM_REQ-1:0]  ack_q, ack_d;
   logic                err_q, err_d;
   logic                busy_q, busy_d;
   logic                start_q, start_d;

   logic                found;
   logic [2:0]          win;
   logic [3:0]          sum;
   logic [2*NUM_REQ-1:0] rot;
   logic [1:0]          win_sel;
   logic [7:0]          win_data;
   logic [NUM_REQ-1:0]  ack_vec;

   // Pick the first asserted request at or above the pointer, wrapping around.
   always_comb begin
      found    = 1'b0;
      win      = '0;
      sum      = '0;
      win_sel  = '0;
      win_data = '0;
      rot      = {req, req} >> ptr_q;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!found && rot[i]) begin
            found = 1'b1;
            sum   = 4'({1'b0, ptr_q}) + 4'(i);
            if (sum >= 4'(NUM_REQ)) begin
               sum = sum - 4'(NUM_REQ);
            end
            win = sum[2:0];
         end
      end
      for (int i = 0; i < NUM_REQ; i++) begin
         if (win == 3'(i)) begin
            win_sel  = req_sel[2*i +: 2];
            win_data = req_data[8*i +: 8];
         end
      end
   end

   // One-hot ack pattern for the requester currently holding the grant.
   always_comb begin
      ack_vec = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         ack_vec[i] = (grant_id_q == 3'(i));
      end
   end

   // Next-state and registered-output logic; outputs change together with the state.
   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      cnt_d      = cnt_q;
      grant_id_d = grant_id_q;
      sel_d      = sel_q;
      data_d     = data_q;
      rx_data_d  = rx_data_q;
      ack_d      = '0;
      err_d      = err_q;
      busy_d     = busy_q;
      start_d    = 1'b0;

      case (state_q)
         IDLE: begin
            if (found) begin
               grant_id_d = win;
               sel_d      = win_sel;
               data_d     = win_data;
`ifdef SPI_ARB_FIXED_PRI_EN
               ptr_d      = 3'd0;
`else
               ptr_d      = (win == 3'(NUM_REQ - 1)) ? 3'd0 : win + 3'd1;
`endif
               start_d    = 1'b1;
               busy_d     = 1'b1;
               err_d      = 1'b0;
               state_d    = LAUNCH;
            end
         end
         LAUNCH: begin
            cnt_d   = '0;
            state_d = WAIT_ACT;
         end
         WAIT_ACT: begin
            if (mst_cs != CS_IDLE) begin
               cnt_d   = '0;
               state_d = WAIT_DONE;
            end else if (cnt_q == CNT_LAST) begin
               ack_d     = ack_vec;
               err_d     = 1'b1;
               rx_data_d = 8'h00;
               state_d   = COMPLETE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         WAIT_DONE: begin
            if (mst_cs == CS_IDLE) begin
               ack_d     = ack_vec;
               err_d     = 1'b0;
               rx_data_d = mst_data_received;
               state_d   = COMPLETE;
            end else if (cnt_q == CNT_LAST) begin
               ack_d     = ack_vec;
               err_d     = 1'b1;
               rx_data_d = 8'h00;
               state_d   = COMPLETE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         COMPLETE: begin
            err_d   = 1'b0;
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: begin
            busy_d  = 1'b0;
            err_d   = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q    <= IDLE;
         ptr_q      <= '0;
         cnt_q      <= '0;
         grant_id_q <= '0;
         sel_q      <= '0;
         data_q     <= '0;
         rx_data_q  <= '0;
         ack_q      <= '0;
         err_q      <= 1'b0;
         busy_q     <= 1'b0;
         start_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         cnt_q      <= cnt_d;
         grant_id_q <= grant_id_d;
         sel_q      <= sel_d;
         data_q     <= data_d;
         rx_data_q  <= rx_data_d;
         ack_q      <= ack_d;
         err_q      <= err_d;
         busy_q     <= busy_d;
         start_q    <= start_d;
      end
   end

   assign ack              = ack_q;
   assign rx_data          = rx_data_q;
   assign err              = err_q;
   assign busy             = busy_q;
   assign grant_id         = grant_id_q;
   assign mst_start        = start_q;
   assign mst_slave_select = sel_q;
   assign mst_data_to_send = data_q;

endmodule

// File: tb/tb_spi_master_arbiter.sv
// Scoreboard bench for spi_master_arbiter with a small SPI Master model.
// The Master model answers each byte with (byte ^ 8'h8D) unless stuck is set.
module tb_spi_master_arbiter;

   localparam int NREQ = 3;
   localparam int TMO  = 64;

   logic              clk;
   logic              reset;
   logic [NREQ-1:0]   req;
   logic [2*NREQ-1:0] req_sel;
   logic [8*NREQ-1:0] req_data;
   logic [NREQ-1:0]   ack;
   logic [7:0]        rx_data;
   logic              err;
   logic              busy;
   logic [2:0]        grant_id;
   logic              mst_start;
   logic [1:0]        mst_slave_select;
   logic [7:0]        mst_data_to_send;
   logic [7:0]        mst_data_received;
   logic [2:0]        mst_cs;

   spi_master_arbiter #(.NUM_REQ(NREQ), .TIMEOUT_CYCLES(TMO)) dut (
      .clk(clk), .reset(reset), .req(req), .req_sel(req_sel), .req_data(req_data),
      .ack(ack), .rx_data(rx_data), .err(err), .busy(busy), .grant_id(grant_id),
      .mst_start(mst_start), .mst_slave_select(mst_slave_select),
      .mst_data_to_send(mst_data_to_send), .mst_data_received(mst_data_received),
      .mst_cs(mst_cs)
   );

   typedef struct {
      logic [2:0] id;
      logic [1:0] sel;
      logic [7:0] data;
      logic [7:0] rx;
      logic       err;
   } exp_t;

   exp_t exp_q[$];
   int   n_total = 0;
   int   n_pass  = 0;
   int   starts  = 0;
   logic stuck   = 1'b0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_total++;
      if (act === expv) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, expv, $time);
   endtask

   task automatic push(input logic [2:0] id, input logic [1:0] sel, input logic [7:0] data,
                       input logic [7:0] rx, input logic e);
      exp_t x;
      x.id = id; x.sel = sel; x.data = data; x.rx = rx; x.err = e;
      exp_q.push_back(x);
   endtask

   task automatic set_req(input int i, input logic [1:0] sel, input logic [7:0] data);
      req_sel[2*i +: 2]  = sel;
      req_data[8*i +: 8] = data;
   endtask

   // Wait (bounded) for the next negedge where ack is nonzero.
   task automatic wait_ack(input string name);
      bit seen;
      seen = 0;
      for (int k = 0; k < 300; k++) begin
         @(negedge clk);
         if (ack != '0) begin seen = 1; break; end
      end
      if (!seen) chk({name, "_ack_timeout"}, 32'd0, 32'd1);
   endtask

   task automatic wait_cs_active(input string name);
      bit seen;
      seen = 0;
      for (int k = 0; k < 50; k++) begin
         @(negedge clk);
         if (mst_cs != 3'b111) begin seen = 1; break; end
      end
      if (!seen) chk({name, "_cs_timeout"}, 32'd0, 32'd1);
   endtask

   // SPI Master model: CS goes active two cycles after start, returns to idle four cycles later.
   initial begin
      logic [1:0] s;
      logic [7:0] d;
      mst_cs = 3'b111;
      mst_data_received = 8'h00;
      forever begin
         @(negedge clk);
         if (reset && mst_start && !stuck) begin
            s = mst_slave_select;
            d = mst_data_to_send;
            repeat (2) @(negedge clk);
            case (s)
               2'd0:    mst_cs = 3'b110;
               2'd1:    mst_cs = 3'b101;
               2'd2:    mst_cs = 3'b011;
               default: mst_cs = 3'b010;
            endcase
            repeat (4) @(negedge clk);
            mst_data_received = d ^ 8'h8D;
            mst_cs = 3'b111;
         end
      end
   end

   // Monitor: checks launches and acks against the scoreboard queue.
   initial begin
      logic prev_start;
      exp_t x;
      prev_start = 1'b0;
      forever begin
         @(negedge clk);
         if (reset) begin
            if (prev_start) chk("start_pulse_width", {31'd0, mst_start}, 32'd0);
            if (mst_start) begin
               starts++;
               if (exp_q.size() == 0) chk("unexpected_start", 32'd1, 32'd0);
               else begin
                  x = exp_q[0];
                  chk("start_grant_id", {29'd0, grant_id}, {29'd0, x.id});
                  chk("start_sel", {30'd0, mst_slave_select}, {30'd0, x.sel});
                  chk("start_data", {24'd0, mst_data_to_send}, {24'd0, x.data});
               end
            end
            if (ack != '0) begin
               if (exp_q.size() == 0) chk("unexpected_ack", {29'd0, ack}, 32'd0);
               else begin
                  x = exp_q.pop_front();
                  chk("ack_vector", {29'd0, ack}, 32'd1 << x.id);
                  chk("ack_rx_data", {24'd0, rx_data}, {24'd0, x.rx});
                  chk("ack_err", {31'd0, err}, {31'd0, x.err});
               end
            end
         end
         prev_start = mst_start;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int s0;
      bit seen;
      reset = 1'b0; req = '0; req_sel = '0; req_data = '0;

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk) reset = 1'b1;
      @(negedge clk);
      chk("rst_ack", {29'd0, ack}, 32'd0);
      chk("rst_rx_data", {24'd0, rx_data}, 32'd0);
      chk("rst_err", {31'd0, err}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_grant_id", {29'd0, grant_id}, 32'd0);
      chk("rst_start", {31'd0, mst_start}, 32'd0);
      chk("rst_sel", {30'd0, mst_slave_select}, 32'd0);
      chk("rst_data", {24'd0, mst_data_to_send}, 32'd0);

      // All three requesting continuously for four transfers
      set_req(0, 2'd0, 8'h11);
      set_req(1, 2'd1, 8'h57);
      set_req(2, 2'd2, 8'hA5);
`ifdef SPI_ARB_FIXED_PRI_EN
      push(3'd0, 2'd0, 8'h11, 8'h9C, 1'b0);
      push(3'd0, 2'd0, 8'h11, 8'h9C, 1'b0);
      push(3'd0, 2'd0, 8'h11, 8'h9C, 1'b0);
      push(3'd0, 2'd0, 8'h11, 8'h9C, 1'b0);
`else
      push(3'd0, 2'd0, 8'h11, 8'h9C, 1'b0);
      push(3'd1, 2'd1, 8'h57, 8'hDA, 1'b0);
      push(3'd2, 2'd2, 8'hA5, 8'h28, 1'b0);
      push(3'd0, 2'd0, 8'h11, 8'h9C, 1'b0);
`endif
      req = 3'b111;
      for (int t = 0; t < 4; t++) wait_ack("rr");
      req = '0;
      repeat (4) @(negedge clk);
      chk("rr_queue_drained", exp_q.size(), 32'd0);

      // Single transfer from requester 1
      set_req(1, 2'd1, 8'h57);
      push(3'd1, 2'd1, 8'h57, 8'hDA, 1'b0);
      req = 3'b010;
      wait_ack("single");
      req = '0;
      repeat (3) @(negedge clk);

      // Requester 2 arrives during requester 0's transfer
      set_req(0, 2'd0, 8'h0F);
      set_req(2, 2'd2, 8'hA5);
      push(3'd0, 2'd0, 8'h0F, 8'h82, 1'b0);
      push(3'd2, 2'd2, 8'hA5, 8'h28, 1'b0);
      req = 3'b001;
      repeat (3) @(negedge clk);
      req = 3'b101;
      wait_ack("overlap0");
      req = 3'b100;
      repeat (2) @(negedge clk);
      chk("overlap_grant_start", {31'd0, mst_start}, 32'd1);
      chk("overlap_grant_id", {29'd0, grant_id}, 32'd2);
      wait_ack("overlap2");
      req = '0;
      repeat (3) @(negedge clk);

      // One-cycle request from requester 1 while busy is ignored
      set_req(0, 2'd0, 8'hC3);
      push(3'd0, 2'd0, 8'hC3, 8'h4E, 1'b0);
      req = 3'b001;
      wait_cs_active("glitch");
      req = 3'b011;
      @(negedge clk);
      req = 3'b001;
      wait_ack("glitch");
      req = '0;
      s0 = starts;
      repeat (20) @(negedge clk);
      chk("glitch_no_new_start", starts, s0);
      chk("glitch_idle_busy", {31'd0, busy}, 32'd0);

      // Master never activates CS: timeout with err
      stuck = 1'b1;
      set_req(2, 2'd2, 8'h3C);
      push(3'd2, 2'd2, 8'h3C, 8'h00, 1'b1);
      req = 3'b100;
      seen = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (mst_start) begin seen = 1; break; end
      end
      chk("tmo_start_seen", {31'd0, seen}, 32'd1);
      n = 0;
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         n++;
         if (ack != '0) break;
      end
      chk("tmo_latency", n, TMO + 1);
      chk("tmo_busy_at_ack", {31'd0, busy}, 32'd1);
      req = '0;
      @(negedge clk);
      chk("tmo_busy_after", {31'd0, busy}, 32'd0);
      stuck = 1'b0;
      repeat (3) @(negedge clk);

      // Reset in the middle of WAIT_DONE abandons the transfer
      set_req(1, 2'd3, 8'h77);
      push(3'd1, 2'd3, 8'h77, 8'h00, 1'b0);
      req = 3'b010;
      wait_cs_active("rst_mid");
      @(negedge clk);
      chk("rst_mid_busy_before", {31'd0, busy}, 32'd1);
      reset = 1'b0;
      @(negedge clk);
      chk("rst_mid_busy", {31'd0, busy}, 32'd0);
      chk("rst_mid_ack", {29'd0, ack}, 32'd0);
      chk("rst_mid_grant_id", {29'd0, grant_id}, 32'd0);
      exp_q.delete();
      req = '0;
      reset = 1'b1;
      repeat (20) @(negedge clk);
      chk("rst_mid_idle", {31'd0, busy}, 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
